// File: rtl/uart_rx_engine.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_engine
// Brief    : 16x-oversampled UART receiver (7/8 data bits, optional parity)
//            with sticky parity/framing/overflow status.
//            Optional macro RX_GLITCH_FILTER_EN inserts a 3-tick majority filter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_engine #(
   parameter bit SYNC_RESET = 1'b0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       baud_clock,
   input  logic       rx,
   input  logic       bit8,
   input  logic       parity_en,
   input  logic       odd_n_even,
   input  logic       read_rx_byte,
   output logic [7:0] rx_byte,
   output logic       rx_ready,
   output logic       parity_err,
   output logic       framing_err,
   output logic       overflow
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic       w_arst_n;
   logic       w_srst;

   generate
      if (SYNC_RESET) begin : g_sync_rst
         assign w_arst_n = 1'b1;
         assign w_srst   = ~reset_n;
      end else begin : g_async_rst
         assign w_arst_n = reset_n;
         assign w_srst   = 1'b0;
      end
   endgenerate

   logic       rx_meta_q, rx_meta_d;
   logic       rx_s_q,    rx_s_d;
   logic [2:0] state_q,   state_d;
   logic [3:0] samp_cnt_q, samp_cnt_d;
   logic [2:0] bit_cnt_q,  bit_cnt_d;
   logic [7:0] shift_q,    shift_d;
   logic       par_bit_q,  par_bit_d;
   logic       stop_bit_q, stop_bit_d;
   logic       load_pend_q, load_pend_d;
   logic [7:0] rx_byte_q,  rx_byte_d;
   logic       rx_ready_q, rx_ready_d;
   logic       perr_q,     perr_d;
   logic       ferr_q,     ferr_d;
   logic       ovf_q,      ovf_d;

   logic       w_rx;
   logic [2:0] w_last_bit;
   logic [7:0] w_data;
   logic       w_perr;

`ifdef RX_GLITCH_FILTER_EN
   logic [2:0] flt_q, flt_d;
   assign w_rx = (flt_q[0] & flt_q[1]) | (flt_q[0] & flt_q[2]) | (flt_q[1] & flt_q[2]);
`else
   assign w_rx = rx_s_q;
`endif

   assign w_last_bit = bit8 ? 3'd7 : 3'd6;
   // 7-bit characters land in shift_q[7:1] after seven right shifts
   assign w_data     = bit8 ? shift_q : {1'b0, shift_q[7:1]};
   assign w_perr     = parity_en & (^w_data ^ par_bit_q ^ odd_n_even);

   always_comb begin
      rx_meta_d   = rx;
      rx_s_d      = rx_meta_q;
      state_d     = state_q;
      samp_cnt_d  = samp_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      par_bit_d   = par_bit_q;
      stop_bit_d  = stop_bit_q;
      load_pend_d = 1'b0;
      rx_byte_d   = rx_byte_q;
      rx_ready_d  = rx_ready_q;
      perr_d      = perr_q;
      ferr_d      = ferr_q;
      ovf_d       = ovf_q;
`ifdef RX_GLITCH_FILTER_EN
      flt_d       = baud_clock ? {flt_q[1:0], rx_s_q} : flt_q;
`endif

      if (baud_clock) begin
         case (state_q)
            S_IDLE: begin
               samp_cnt_d = 4'd0;
               if (!w_rx) state_d = S_START;
            end
            S_START: begin
               if (samp_cnt_q == 4'd7) begin
                  samp_cnt_d = 4'd0;
                  bit_cnt_d  = 3'd0;
                  state_d    = w_rx ? S_IDLE : S_DATA;
               end else begin
                  samp_cnt_d = samp_cnt_q + 4'd1;
               end
            end
            S_DATA: begin
               samp_cnt_d = samp_cnt_q + 4'd1;
               if (samp_cnt_q == 4'd15) begin
                  shift_d   = {w_rx, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == w_last_bit) state_d = parity_en ? S_PARITY : S_STOP;
               end
            end
            S_PARITY: begin
               samp_cnt_d = samp_cnt_q + 4'd1;
               if (samp_cnt_q == 4'd15) begin
                  par_bit_d = w_rx;
                  state_d   = S_STOP;
               end
            end
            S_STOP: begin
               samp_cnt_d = samp_cnt_q + 4'd1;
               if (samp_cnt_q == 4'd15) begin
                  stop_bit_d  = w_rx;
                  load_pend_d = 1'b1;
                  state_d     = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // A read clears status first so a coincident load overrides it
      if (read_rx_byte) begin
         rx_ready_d = 1'b0;
         perr_d     = 1'b0;
         ferr_d     = 1'b0;
         ovf_d      = 1'b0;
      end
      if (load_pend_q) begin
         if (!rx_ready_q || read_rx_byte) begin
            rx_byte_d  = w_data;
            rx_ready_d = 1'b1;
            perr_d     = w_perr;
         end else begin
            ovf_d = 1'b1;
         end
         if (!stop_bit_q) ferr_d = 1'b1;
      end

      if (w_srst) begin
         rx_meta_d   = 1'b1;
         rx_s_d      = 1'b1;
         state_d     = S_IDLE;
         samp_cnt_d  = 4'd0;
         bit_cnt_d   = 3'd0;
         shift_d     = 8'h00;
         par_bit_d   = 1'b0;
         stop_bit_d  = 1'b1;
         load_pend_d = 1'b0;
         rx_byte_d   = 8'h00;
         rx_ready_d  = 1'b0;
         perr_d      = 1'b0;
         ferr_d      = 1'b0;
         ovf_d       = 1'b0;
`ifdef RX_GLITCH_FILTER_EN
         flt_d       = 3'b111;
`endif
      end
   end

   always_ff @(posedge clk or negedge w_arst_n) begin
      if (!w_arst_n) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         state_q     <= S_IDLE;
         samp_cnt_q  <= 4'd0;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         par_bit_q   <= 1'b0;
         stop_bit_q  <= 1'b1;
         load_pend_q <= 1'b0;
         rx_byte_q   <= 8'h00;
         rx_ready_q  <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         ovf_q       <= 1'b0;
`ifdef RX_GLITCH_FILTER_EN
         flt_q       <= 3'b111;
`endif
      end else begin
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
         state_q     <= state_d;
         samp_cnt_q  <= samp_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_bit_q   <= par_bit_d;
         stop_bit_q  <= stop_bit_d;
         load_pend_q <= load_pend_d;
         rx_byte_q   <= rx_byte_d;
         rx_ready_q  <= rx_ready_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
         ovf_q       <= ovf_d;
`ifdef RX_GLITCH_FILTER_EN
         flt_q       <= flt_d;
`endif
      end
   end

   assign rx_byte     = rx_byte_q;
   assign rx_ready    = rx_ready_q;
   assign parity_err  = perr_q;
   assign framing_err = ferr_q;
   assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx_engine
// Brief    : Self-checking bench for uart_rx_engine against a character-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_engine;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       baud_clock = 1'b0;
   logic       rx = 1'b1;
   logic       bit8 = 1'b1;
   logic       parity_en = 1'b0;
   logic       odd_n_even = 1'b0;
   logic       read_rx_byte = 1'b0;
   logic [7:0] rx_byte;
   logic       rx_ready, parity_err, framing_err, overflow;

   int         n_checks = 0;
   int         n_pass = 0;
   logic [1:0] bdiv = 2'd0;
   int         cyc = 0;

   logic [7:0] m_byte;
   logic       m_ready, m_perr, m_ferr, m_ovf;
   logic [11:0] obs;

   uart_rx_engine dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .baud_clock  (baud_clock),
      .rx          (rx),
      .bit8        (bit8),
      .parity_en   (parity_en),
      .odd_n_even  (odd_n_even),
      .read_rx_byte(read_rx_byte),
      .rx_byte     (rx_byte),
      .rx_ready    (rx_ready),
      .parity_err  (parity_err),
      .framing_err (framing_err),
      .overflow    (overflow)
   );

   assign obs = {rx_byte, rx_ready, parity_err, framing_err, overflow};

   always #5 clk = ~clk;

   always @(posedge clk) begin
      bdiv       <= bdiv + 2'd1;
      baud_clock <= (bdiv == 2'd3);
      cyc        <= cyc + 1;
   end

   function automatic logic [11:0] exp_vec();
      return {m_byte, m_ready, m_perr, m_ferr, m_ovf};
   endfunction

   function automatic int popcnt(input logic [7:0] v);
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(v[i]);
      return n;
   endfunction

   task automatic model_reset();
      m_byte = 8'h00; m_ready = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic model_read();
      m_ready = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
   endtask

   // Character-level outcome of one received frame; rd = read in the load clock
   task automatic model_frame(input logic [7:0] d, input logic pbit, input logic stop, input logic rd);
      logic [7:0] data;
      int         ones;
      logic       perr;
      data = bit8 ? d : {1'b0, d[6:0]};
      ones = popcnt(data) + int'(pbit);
      perr = parity_en && ((ones % 2) != int'(odd_n_even));
      if (rd) model_read();
      if (!m_ready) begin
         m_byte = data; m_ready = 1'b1; m_perr = perr;
      end else begin
         m_ovf = 1'b1;
      end
      if (!stop) m_ferr = 1'b1;
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      repeat (64) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int nbits);
      for (int i = 0; i < nbits; i++) send_bit(1'b1);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < (bit8 ? 8 : 7); i++) send_bit(d[i]);
      if (parity_en) send_bit(pbit);
      send_bit(stop);
      rx = 1'b1;
   endtask

   task automatic align();
      do begin
         @(posedge clk);
         #1;
      end while (bdiv != 2'd0);
   endtask

   task automatic do_read();
      read_rx_byte = 1'b1;
      @(posedge clk);
      #1;
      read_rx_byte = 1'b0;
      model_read();
   endtask

   task automatic test_reset();
      n_checks++;
      if (obs !== 12'h000) $display("FAIL reset_state: got %h expected %h", obs, 12'h000);
      else n_pass++;
   endtask

   task automatic test_8n1();
      bit8 = 1'b1; parity_en = 1'b0;
      align();
      send_frame(8'hA5, 1'b0, 1'b1);
      model_frame(8'hA5, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (obs !== {8'hA5, 4'b1000}) $display("FAIL 8n1_a5: got %h expected %h", obs, {8'hA5, 4'b1000});
      else n_pass++;
      idle(2);
      do_read();
      n_checks++;
      if (obs !== {8'hA5, 4'b0000}) $display("FAIL 8n1_read: got %h expected %h", obs, {8'hA5, 4'b0000});
      else n_pass++;
   endtask

   task automatic test_7e1();
      bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
      send_frame(8'h41, 1'b0, 1'b1);
      model_frame(8'h41, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (obs !== {8'h41, 4'b1000}) $display("FAIL 7e1_good: got %h expected %h", obs, {8'h41, 4'b1000});
      else n_pass++;
      idle(2);
      do_read();
      send_frame(8'h41, 1'b1, 1'b1);
      model_frame(8'h41, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (obs !== {8'h41, 4'b1100}) $display("FAIL 7e1_bad: got %h expected %h", obs, {8'h41, 4'b1100});
      else n_pass++;
      idle(2);
      do_read();
   endtask

   task automatic test_8o1();
      bit8 = 1'b1; parity_en = 1'b1; odd_n_even = 1'b1;
      send_frame(8'h00, 1'b0, 1'b1);
      model_frame(8'h00, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (parity_err !== 1'b1 || obs !== exp_vec()) $display("FAIL 8o1_p0: got %h expected %h", obs, exp_vec());
      else n_pass++;
      idle(2);
      do_read();
      send_frame(8'h00, 1'b1, 1'b1);
      model_frame(8'h00, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (parity_err !== 1'b0 || obs !== exp_vec()) $display("FAIL 8o1_p1: got %h expected %h", obs, exp_vec());
      else n_pass++;
      idle(2);
      do_read();
   endtask

   task automatic test_overflow();
      bit8 = 1'b1; parity_en = 1'b0;
      send_frame(8'h11, 1'b0, 1'b1);
      model_frame(8'h11, 1'b0, 1'b1, 1'b0);
      idle(2);
      send_frame(8'h22, 1'b0, 1'b1);
      model_frame(8'h22, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (obs !== {8'h11, 4'b1001}) $display("FAIL overflow_hold: got %h expected %h", obs, {8'h11, 4'b1001});
      else n_pass++;
      idle(2);
      do_read();
      n_checks++;
      if (obs[3:0] !== 4'b0000 || obs !== exp_vec()) $display("FAIL overflow_read: got %h expected %h", obs, exp_vec());
      else n_pass++;
   endtask

   task automatic test_false_start();
      align();
      rx = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rx = 1'b1;
      idle(4);
      n_checks++;
      if (rx_ready !== 1'b0 || obs !== exp_vec()) $display("FAIL false_start: got %h expected %h", obs, exp_vec());
      else n_pass++;
   endtask

   task automatic test_framing();
      send_frame(8'h3C, 1'b0, 1'b0);
      model_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs !== {8'h3C, 4'b1010}) $display("FAIL framing: got %h expected %h", obs, {8'h3C, 4'b1010});
      else n_pass++;
      idle(2);
      do_read();
   endtask

   task automatic test_reset_mid();
      align();
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rx = 1'b1;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL reset_mid_state: got %h expected %h", obs, exp_vec());
      else n_pass++;
      reset_n = 1'b1;
      idle(2);
      send_frame(8'h5A, 1'b0, 1'b1);
      model_frame(8'h5A, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (obs !== {8'h5A, 4'b1000}) $display("FAIL reset_mid_5a: got %h expected %h", obs, {8'h5A, 4'b1000});
      else n_pass++;
      idle(2);
   endtask

   task automatic test_read_same_clk();
      int t0;
      int off = 0;
      bit8 = 1'b1; parity_en = 1'b0;
      do_read();
      align();
      t0 = cyc;
      fork
         send_frame(8'h96, 1'b0, 1'b1);
         begin
            for (int i = 0; i < 1200; i++) begin
               @(posedge clk);
               #1;
               if (rx_ready === 1'b1) begin
                  off = cyc - t0;
                  break;
               end
            end
         end
      join
      model_frame(8'h96, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (off == 0 || obs !== exp_vec()) $display("FAIL same_clk_first: got %h expected %h load_offset=%0d", obs, exp_vec(), off);
      else n_pass++;
      idle(2);
      align();
      fork
         send_frame(8'hC3, 1'b0, 1'b1);
         begin
            if (off > 1) begin
               repeat (off - 1) @(posedge clk);
               #1;
               read_rx_byte = 1'b1;
               @(posedge clk);
               #1;
               read_rx_byte = 1'b0;
            end
         end
      join
      model_frame(8'hC3, 1'b0, 1'b1, 1'b1);
      n_checks++;
      if (rx_ready !== 1'b1 || obs !== exp_vec()) $display("FAIL same_clk_load: got %h expected %h", obs, exp_vec());
      else n_pass++;
      idle(2);
      do_read();
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic       pbit, stop;
      for (int it = 0; it < 24; it++) begin
         bit8       = 1'($urandom_range(0, 1));
         parity_en  = 1'($urandom_range(0, 1));
         odd_n_even = 1'($urandom_range(0, 1));
         d          = 8'($urandom);
         pbit       = 1'($urandom_range(0, 1));
         stop       = ($urandom_range(0, 3) != 0);
         send_frame(d, pbit, stop);
         model_frame(d, pbit, stop, 1'b0);
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL random_%0d: got %h expected %h", it, obs, exp_vec());
         else n_pass++;
         idle(2);
         if ($urandom_range(0, 1) == 1) do_read();
      end
   endtask

   initial begin
      model_reset();
      repeat (5) @(posedge clk);
      #1;
      test_reset();
      reset_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      test_8n1();
      test_7e1();
      test_8o1();
      test_overflow();
      test_false_start();
      test_framing();
      test_reset_mid();
      test_read_same_clk();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
